// File: rtl/gold_support_scanner_pkg.sv
// rtl/gold_support_scanner_pkg.sv - shared constants and scan state type for the gold support scanner
package gold_pkg;
    localparam int OBJECT_SIZE         = 32;
    localparam int SCREEN_BOTTOM       = 480;
    localparam int SUPPORT_MIN_DEF     = 4;
    localparam int DEBOUNCE_FRAMES_DEF = 2;

    typedef enum logic [1:0] {
        S_WAIT_SOF,
        S_ACCUM,
        S_EVAL
    } scan_state_t;

    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction
endpackage

// File: rtl/gold_support_scanner_if.sv
// rtl/gold_support_scanner_if.sv - raster/sack inputs and support outputs of the scanner
interface gold_support_scanner_if;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        dirt_dr;
    logic [10:0] goldTLX_a;
    logic [10:0] goldTLY_a;
    logic [10:0] goldTLX_b;
    logic [10:0] goldTLY_b;
    logic        can_fall_a;
    logic        can_fall_b;
    logic [5:0]  support_cnt_a;
    logic [5:0]  support_cnt_b;

    modport master (
        output startOfFrame, pixelX, pixelY, dirt_dr,
        output goldTLX_a, goldTLY_a, goldTLX_b, goldTLY_b,
        input  can_fall_a, can_fall_b, support_cnt_a, support_cnt_b
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, dirt_dr,
        input  goldTLX_a, goldTLY_a, goldTLX_b, goldTLY_b,
        output can_fall_a, can_fall_b, support_cnt_a, support_cnt_b
    );
endinterface

// File: rtl/gold_probe_counter.sv
// rtl/gold_probe_counter.sv - per-sack probe-row dirt counter, debounce and support outputs
module gold_probe_counter
    import gold_pkg::*;
#(
    parameter int OBJECT_W        = OBJECT_SIZE,
    parameter int OBJECT_H        = OBJECT_SIZE,
    parameter int SUPPORT_MIN     = SUPPORT_MIN_DEF,
    parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF,
    parameter int SCREEN_BOTTOM   = gold_pkg::SCREEN_BOTTOM
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        snap_i,
    input  logic        accum_i,
    input  logic        eval_i,
    input  logic [10:0] pixel_x_i,
    input  logic [10:0] pixel_y_i,
    input  logic        dirt_i,
    input  logic [10:0] tlx_i,
    input  logic [10:0] tly_i,
    output logic        can_fall_o,
    output logic [5:0]  support_cnt_o
);
    localparam int DW = (DEBOUNCE_FRAMES < 2) ? 1 : $clog2(DEBOUNCE_FRAMES + 1);

    logic [10:0]   tlx_q, tly_q;
    logic [5:0]    acc_q;
    logic [DW-1:0] deb_q, deb_d;
    logic          can_fall_q;
    logic [5:0]    cnt_q;
    logic [11:0]   probe_y, x_lo, x_hi;
    logic          hit, floor_hit, unsupported;

    // 12-bit arithmetic so a probe row below the 11-bit raster reads as floor
    always_comb begin
        probe_y     = {1'b0, tly_q} + 12'(OBJECT_H);
        x_lo        = {1'b0, tlx_q};
        x_hi        = x_lo + 12'(OBJECT_W - 1);
        hit         = dirt_i && ({1'b0, pixel_y_i} == probe_y) &&
                      ({1'b0, pixel_x_i} >= x_lo) && ({1'b0, pixel_x_i} <= x_hi);
        floor_hit   = probe_y[11] || (probe_y >= 12'(SCREEN_BOTTOM));
        unsupported = ({1'b0, acc_q} < 7'(SUPPORT_MIN)) && !floor_hit;
        deb_d       = '0;
        if (unsupported) begin
            deb_d = (deb_q == DW'(DEBOUNCE_FRAMES)) ? deb_q : deb_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            tlx_q      <= '0;
            tly_q      <= '0;
            acc_q      <= '0;
            deb_q      <= '0;
            can_fall_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (snap_i) begin
                tlx_q <= tlx_i;
                tly_q <= tly_i;
                acc_q <= '0;
            end else if (accum_i && hit) begin
                acc_q <= sat_inc6(acc_q);
            end
            if (eval_i) begin
                deb_q      <= deb_d;
                can_fall_q <= (deb_d == DW'(DEBOUNCE_FRAMES));
                cnt_q      <= acc_q;
            end
        end
    end

    assign can_fall_o    = can_fall_q;
    assign support_cnt_o = cnt_q;
endmodule

// File: rtl/gold_support_scanner.sv
// rtl/gold_support_scanner.sv - frame FSM driving two sack probe counters
module gold_support_scanner
    import gold_pkg::*;
#(
    parameter int OBJECT_W        = OBJECT_SIZE,
    parameter int OBJECT_H        = OBJECT_SIZE,
    parameter int SUPPORT_MIN     = SUPPORT_MIN_DEF,
    parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEF,
    parameter int SCREEN_BOTTOM   = gold_pkg::SCREEN_BOTTOM
) (
    input  logic                   clk,
    input  logic                   resetN,
    gold_support_scanner_if.slave  bus
);
    scan_state_t state_q, state_d;
    logic        snap, accum, eval_s;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= S_WAIT_SOF;
        else         state_q <= state_d;
    end

    // SOF during S_EVAL is not legal and is simply not looked at
    always_comb begin
        state_d = state_q;
        snap    = 1'b0;
        accum   = 1'b0;
        eval_s  = 1'b0;
        case (state_q)
            S_WAIT_SOF: begin
                snap = bus.startOfFrame;
                if (bus.startOfFrame) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                accum = 1'b1;
                if (bus.startOfFrame) state_d = S_EVAL;
            end
            S_EVAL: begin
                snap    = 1'b1;
                eval_s  = 1'b1;
                state_d = S_ACCUM;
            end
            default: state_d = S_WAIT_SOF;
        endcase
    end

    gold_probe_counter #(
        .OBJECT_W(OBJECT_W), .OBJECT_H(OBJECT_H), .SUPPORT_MIN(SUPPORT_MIN),
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES), .SCREEN_BOTTOM(SCREEN_BOTTOM)
    ) u_probe_a (
        .clk(clk), .resetN(resetN), .snap_i(snap), .accum_i(accum), .eval_i(eval_s),
        .pixel_x_i(bus.pixelX), .pixel_y_i(bus.pixelY), .dirt_i(bus.dirt_dr),
        .tlx_i(bus.goldTLX_a), .tly_i(bus.goldTLY_a),
        .can_fall_o(bus.can_fall_a), .support_cnt_o(bus.support_cnt_a)
    );

    gold_probe_counter #(
        .OBJECT_W(OBJECT_W), .OBJECT_H(OBJECT_H), .SUPPORT_MIN(SUPPORT_MIN),
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES), .SCREEN_BOTTOM(SCREEN_BOTTOM)
    ) u_probe_b (
        .clk(clk), .resetN(resetN), .snap_i(snap), .accum_i(accum), .eval_i(eval_s),
        .pixel_x_i(bus.pixelX), .pixel_y_i(bus.pixelY), .dirt_i(bus.dirt_dr),
        .tlx_i(bus.goldTLX_b), .tly_i(bus.goldTLY_b),
        .can_fall_o(bus.can_fall_b), .support_cnt_o(bus.support_cnt_b)
    );
endmodule
